// File: rtl/ex_result_stage.sv
// EX-stage result select, EX/MEM pipeline register and architectural HI/LO.
// Define EX_HILO_EN to build the HI/LO registers; without it hi/lo read as zero.
module ex_result_stage #(
  parameter int WIDTH       = 32,
  parameter int RN_W        = 5,
  parameter int LINK_OFFSET = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       esel,
  input  logic [WIDTH-1:0] ealu,
  input  logic [WIDTH-1:0] epc,
  input  logic [RN_W-1:0]  ern,
  input  logic             ewreg,
  input  logic             ewhi,
  input  logic             ewlo,
  input  logic [WIDTH-1:0] ehi_in,
  input  logic [WIDTH-1:0] elo_in,
  output logic [WIDTH-1:0] er,
  output logic [WIDTH-1:0] mr,
  output logic [RN_W-1:0]  mrn,
  output logic             mwreg,
  output logic             mvalid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             advance;
  logic [WIDTH-1:0] linkAddr;

  logic [WIDTH-1:0] mr_q, mr_d;
  logic [RN_W-1:0]  mrn_q, mrn_d;
  logic             mwreg_q, mwreg_d;
  logic             mvalid_q, mvalid_d;

  assign advance  = e_valid & ~stall & ~flush;
  assign linkAddr = epc + WIDTH'(LINK_OFFSET);

  // Forwarding result; hi/lo are the pre-write values, so a reader that also writes sees old data.
  always_comb begin
    er = '0;
    case (esel)
      2'd0: er = ealu;
      2'd1: er = linkAddr;
      2'd2: er = hi;
      2'd3: er = lo;
      default: er = '0;
    endcase
  end

  always_comb begin
    mr_d     = mr_q;
    mrn_d    = mrn_q;
    mwreg_d  = mwreg_q;
    mvalid_d = mvalid_q;
    if (flush) begin
      mr_d     = '0;
      mrn_d    = '0;
      mwreg_d  = 1'b0;
      mvalid_d = 1'b0;
    end else if (!stall) begin
      mr_d     = er;
      mrn_d    = ern;
      mwreg_d  = ewreg & e_valid & (ern != '0);
      mvalid_d = e_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mr_q     <= '0;
      mrn_q    <= '0;
      mwreg_q  <= 1'b0;
      mvalid_q <= 1'b0;
    end else begin
      mr_q     <= mr_d;
      mrn_q    <= mrn_d;
      mwreg_q  <= mwreg_d;
      mvalid_q <= mvalid_d;
    end
  end

  assign mr     = mr_q;
  assign mrn    = mrn_q;
  assign mwreg  = mwreg_q;
  assign mvalid = mvalid_q;

`ifdef EX_HILO_EN
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (advance && ewhi) hi_d = ehi_in;
    if (advance && ewlo) lo_d = elo_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`else
  logic unusedHilo;

  assign unusedHilo = ^{advance, ewhi, ewlo, ehi_in, elo_in};
  assign hi = '0;
  assign lo = '0;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed plus short random test of ex_result_stage using an expected-value queue.
// Works with or without EX_HILO_EN defined.
module tb_ex_result_stage;

   typedef struct packed {
      logic [31:0] mr;
      logic [4:0]  mrn;
      logic        mwreg;
      logic        mvalid;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

`ifdef EX_HILO_EN
   localparam bit hiloEn = 1'b1;
`else
   localparam bit hiloEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, eValid, stall, flush;
   logic [1:0]  esel;
   logic [31:0] ealu, epc, ehiIn, eloIn;
   logic [4:0]  ern;
   logic        ewreg, ewhi, ewlo;
   logic [31:0] er, mr, hi, lo;
   logic [4:0]  mrn;
   logic        mwreg, mvalid;

   exp_t sbQ[$];
   exp_t mdl;
   int   checks = 0;
   int   errors = 0;

   ex_result_stage dut (
      .clk(clk), .rst(rst), .e_valid(eValid), .stall(stall), .flush(flush),
      .esel(esel), .ealu(ealu), .epc(epc), .ern(ern), .ewreg(ewreg),
      .ewhi(ewhi), .ewlo(ewlo), .ehi_in(ehiIn), .elo_in(eloIn),
      .er(er), .mr(mr), .mrn(mrn), .mwreg(mwreg), .mvalid(mvalid),
      .hi(hi), .lo(lo)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         e = sbQ.pop_front();
         checkField("mr", mr, e.mr);
         checkField("mrn", {27'd0, mrn}, {27'd0, e.mrn});
         checkField("mwreg", {31'd0, mwreg}, {31'd0, e.mwreg});
         checkField("mvalid", {31'd0, mvalid}, {31'd0, e.mvalid});
         checkField("hi", hi, e.hi);
         checkField("lo", lo, e.lo);
      end
   endtask

   // Drive one EX cycle, check the forwarding result, queue the expected MEM-side state, clock it.
   task automatic applyStimulus(input logic r, input logic v, input logic s, input logic f,
                                input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                                input logic [4:0] rn, input logic wr, input logic wh, input logic wl,
                                input logic [31:0] hin, input logic [31:0] lin);
      logic [31:0] erExp;
      exp_t        nxt;
      rst = r; eValid = v; stall = s; flush = f; esel = sel; ealu = alu; epc = pc;
      ern = rn; ewreg = wr; ewhi = wh; ewlo = wl; ehiIn = hin; eloIn = lin;
      #1;
      case (sel)
         2'd0:    erExp = alu;
         2'd1:    erExp = pc + 32'd8;
         2'd2:    erExp = mdl.hi;
         default: erExp = mdl.lo;
      endcase
      checkField("er", er, erExp);
      nxt = mdl;
      if (r) begin
         nxt = '0;
      end else if (f) begin
         nxt.mr = '0; nxt.mrn = '0; nxt.mwreg = 1'b0; nxt.mvalid = 1'b0;
      end else if (!s) begin
         nxt.mr     = erExp;
         nxt.mrn    = rn;
         nxt.mwreg  = wr && v && (rn != 5'd0);
         nxt.mvalid = v;
         if (hiloEn && v && wh) nxt.hi = hin;
         if (hiloEn && v && wl) nxt.lo = lin;
      end
      mdl = nxt;
      sbQ.push_back(nxt);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      mdl = '0;
      $display("[TB] start, HI/LO enabled = %0d", hiloEn);
      // reset
      applyStimulus(1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 1, 0, 0, 2'd0, 32'h9, 32'h0, 5'd3, 1, 1, 1, 32'h1, 32'h2);
      // link address wraps
      applyStimulus(0, 1, 0, 0, 2'd1, 32'h0, 32'hFFFF_FFFC, 5'd31, 1, 0, 0, 32'h0, 32'h0);
      checkField("linkWrapMr", mr, 32'h4);
      // HI write while reading HI sees old value, then the new value
      applyStimulus(0, 1, 0, 0, 2'd2, 32'h0, 32'h100, 5'd2, 1, 1, 0, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(0, 1, 0, 0, 2'd2, 32'h0, 32'h104, 5'd3, 1, 0, 0, 32'h0, 32'h0);
      checkField("hiReadBack", mr, hiloEn ? 32'hDEAD_BEEF : 32'h0);
      // both HI and LO in one cycle, then read LO
      applyStimulus(0, 1, 0, 0, 2'd3, 32'h0, 32'h108, 5'd4, 1, 1, 1, 32'h0BAD_F00D, 32'h1234_5678);
      applyStimulus(0, 1, 0, 0, 2'd3, 32'h0, 32'h10C, 5'd5, 1, 0, 0, 32'h0, 32'h0);
      // stall for three cycles with a pending HI write
      applyStimulus(0, 1, 0, 0, 2'd0, 32'h11, 32'h110, 5'd6, 1, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 1, 1, 0, 2'd0, 32'h22, 32'h114, 5'd7, 1, 1, 0, 32'hCAFE_0000, 32'h0);
      checkField("stallHoldMr", mr, 32'h11);
      applyStimulus(0, 1, 0, 0, 2'd0, 32'h22, 32'h114, 5'd7, 1, 1, 0, 32'hCAFE_0000, 32'h0);
      checkField("stallReleaseMr", mr, 32'h22);
      // flush wins over stall, LO untouched
      applyStimulus(0, 1, 1, 1, 2'd0, 32'h33, 32'h118, 5'd8, 1, 0, 1, 32'h0, 32'h0000_0BAD);
      // r0 destination discards the write enable
      applyStimulus(0, 1, 0, 0, 2'd0, 32'h5, 32'h11C, 5'd0, 1, 0, 0, 32'h0, 32'h0);
      // bubble loads with mvalid low
      applyStimulus(0, 0, 0, 0, 2'd0, 32'h77, 32'h120, 5'd9, 1, 1, 1, 32'h1, 32'h2);
      // reset during stall with a HI write
      applyStimulus(0, 1, 0, 0, 2'd0, 32'h44, 32'h124, 5'd10, 1, 1, 1, 32'hAAAA_0001, 32'hBBBB_0002);
      applyStimulus(1, 1, 1, 0, 2'd0, 32'h55, 32'h128, 5'd11, 1, 1, 1, 32'h3, 32'h4);
      // short random run
      for (int i = 0; i < 40; i++) begin
         logic        rv, rs, rf, rw, rh, rl;
         logic [1:0]  rsel;
         logic [4:0]  rrn;
         rv   = 1'($urandom_range(0, 3) != 0);
         rs   = 1'($urandom_range(0, 3) == 0);
         rf   = 1'($urandom_range(0, 7) == 0);
         rw   = 1'($urandom_range(0, 1));
         rh   = 1'($urandom_range(0, 1));
         rl   = 1'($urandom_range(0, 1));
         rsel = 2'($urandom_range(0, 3));
         rrn  = 5'($urandom_range(0, 31));
         applyStimulus(0, rv, rs, rf, rsel, $urandom, $urandom, rrn, rw, rh, rl, $urandom, $urandom);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
